// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer: FSM state encoding,
// default sizing and the Owner encoding.
package countdown_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int PRESCALE_DEF = 4;
  localparam int WIDTH_DEF    = 4;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Requester handshake plus the counter control/status bundle seen by the sequencer.
interface countdown_sequencer_if
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             ReqA;
  logic             ReqB;
  logic [WIDTH-1:0] ValueA;
  logic [WIDTH-1:0] ValueB;
  logic             Abort;
  logic             GntA;
  logic             GntB;
  logic             DoneA;
  logic             DoneB;
  logic             Busy;
  logic             Owner;
  logic             CntLoad;
  logic             CntDec;
  logic [WIDTH-1:0] CntDataIn;
  logic [WIDTH-1:0] CntDataOut;

  modport slave (
    input  ReqA, ReqB, ValueA, ValueB, Abort, CntDataOut,
    output GntA, GntB, DoneA, DoneB, Busy, Owner, CntLoad, CntDec, CntDataIn
  );

  modport master (
    output ReqA, ReqB, ValueA, ValueB, Abort, CntDataOut,
    input  GntA, GntB, DoneA, DoneB, Busy, Owner, CntLoad, CntDec, CntDataIn
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the last-served pointer advances only when
// the caller commits a grant through upd.
module rr_arbiter2
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  output logic any_req,
  output logic win
);
  logic last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= OWN_B;
    end else if (upd) begin
      last <= win;
    end
  end

  assign any_req = req_a | req_b;
  // On a tie the requester that was not served last wins.
  assign win = (req_a && req_b) ? ~last : (req_b ? OWN_B : OWN_A);
endmodule

// File: rtl/countdown_sequencer.sv
// Shares one loadable down-counter between two requesters: arbitrates,
// loads the count, paces decrements by PRESCALE and pulses Done at zero.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int WIDTH    = WIDTH_DEF
) (
  input logic                  Clk,
  input logic                  Rst_n,
  countdown_sequencer_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] value;
  logic             owner;
  logic             any_req;
  logic             win;
  logic             upd;

  assign upd = (state == S_IDLE) && any_req;

  rr_arbiter2 u_arb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .req_a  (bus.ReqA),
    .req_b  (bus.ReqB),
    .upd    (upd),
    .any_req(any_req),
    .win    (win)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      presc <= '0;
      value <= '0;
      owner <= OWN_A;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            value <= (win == OWN_B) ? bus.ValueB : bus.ValueA;
            owner <= win;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.Abort) begin
            state <= S_IDLE;
          end else begin
            presc <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.Abort) begin
            state <= S_IDLE;
          end else begin
            presc <= (presc == PMAX) ? '0 : presc + PW'(1);
            if (bus.CntDataOut == '0) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; only CntDec looks at the live counter.
  assign bus.GntA      = (state == S_LOAD) && (owner == OWN_A);
  assign bus.GntB      = (state == S_LOAD) && (owner == OWN_B);
  assign bus.DoneA     = (state == S_DONE) && (owner == OWN_A);
  assign bus.DoneB     = (state == S_DONE) && (owner == OWN_B);
  assign bus.Busy      = (state != S_IDLE);
  assign bus.Owner     = owner;
  assign bus.CntLoad   = (state == S_LOAD);
  assign bus.CntDataIn = value;
  assign bus.CntDec    = (state == S_RUN) && (presc == PMAX) &&
                         (bus.CntDataOut != '0) && !bus.Abort;
endmodule

// File: tb/tb_countdown_sequencer.sv
// Randomised and directed bench for countdown_sequencer with a schedule-based
// reference model feeding an event scoreboard.
module tb_countdown_sequencer;
  localparam int P = 4;

  typedef struct {
    int cyc;
    int kind;   // 0 GntA, 1 GntB, 2 Dec, 3 DoneA, 4 DoneB
    int val;
  } ev_t;

  logic Clk;
  logic Rst_n;
  int   cyc = 0;
  logic [3:0] cnt = 4'd0;

  countdown_sequencer_if #(.WIDTH(4)) bus ();

  countdown_sequencer #(.PRESCALE(P), .WIDTH(4)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural loadable down-counter standing in for the shared instance.
  always @(posedge Clk) begin
    if (bus.CntLoad) cnt <= bus.CntDataIn;
    else if (bus.CntDec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign bus.CntDataOut = cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  ev_t exp_q[$];
  int  busy_start = 0;
  int  busy_end   = -1;
  int  done_cyc   = -1;
  bit  ptr        = 1'b1;

  task automatic drop_from(input int c, input bit keep_gnt);
    ev_t keep[$];
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc < c || (keep_gnt && exp_q[i].kind <= 1)) keep.push_back(exp_q[i]);
    end
    exp_q = keep;
  endtask

  always @(negedge Clk) begin : model
    int now;
    int n;
    bit w;
    now = cyc;
    if (!Rst_n) begin
      if (now <= busy_end) begin
        drop_from(now + 1, 1'b0);
        busy_end = now;
      end
      ptr = 1'b1;
    end else if (now <= busy_end) begin
      if (bus.Abort && now < done_cyc) begin
        drop_from(now, 1'b1);
        busy_end = now;
      end
    end else if (bus.ReqA || bus.ReqB) begin
      w   = (bus.ReqA && bus.ReqB) ? !ptr : bus.ReqB;
      ptr = w;
      n   = w ? int'(bus.ValueB) : int'(bus.ValueA);
      exp_q.push_back('{now + 1, w ? 1 : 0, n});
      for (int k = 1; k <= n; k++) exp_q.push_back('{now + 1 + k * P, 2, 0});
      done_cyc = now + 3 + n * P;
      exp_q.push_back('{done_cyc, w ? 4 : 3, 0});
      busy_start = now + 1;
      busy_end   = done_cyc;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int gnt_cyc_q[$];
  int gnt_who_q[$];
  int done_cyc_q[$];
  int dec_cyc_q[$];

  always @(negedge Clk) begin : monitor
    ev_t ev;
    logic [5:0] e_exp;
    logic [5:0] e_act;
    int  gval;
    int  gwho;
    bit  have_g;
    #1;
    if (cyc >= 1) begin
      e_exp  = '0;
      have_g = 1'b0;
      gval   = 0;
      gwho   = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        if (ev.cyc < cyc) begin
          check("stale_event", ev.cyc, cyc);
        end else begin
          case (ev.kind)
            0: begin e_exp[5] = 1'b1; e_exp[4] = 1'b1; have_g = 1'b1; gval = ev.val; gwho = 0; end
            1: begin e_exp[5] = 1'b1; e_exp[3] = 1'b1; have_g = 1'b1; gval = ev.val; gwho = 1; end
            2: e_exp[2] = 1'b1;
            3: e_exp[1] = 1'b1;
            default: e_exp[0] = 1'b1;
          endcase
        end
      end
      e_act = {bus.CntLoad, bus.GntA, bus.GntB, bus.CntDec, bus.DoneA, bus.DoneB};
      if (e_exp != '0 || e_act != '0) check("events{load,gA,gB,dec,dA,dB}", int'(e_act), int'(e_exp));
      if (have_g) begin
        check("load_value", int'(bus.CntDataIn), gval);
        check("owner_at_grant", int'(bus.Owner), gwho);
      end
      check("busy", int'(bus.Busy), (cyc >= busy_start && cyc <= busy_end) ? 1 : 0);
      if (bus.GntA || bus.GntB) begin
        gnt_cyc_q.push_back(cyc);
        gnt_who_q.push_back(bus.GntB ? 1 : 0);
      end
      if (bus.DoneA || bus.DoneB) done_cyc_q.push_back(cyc);
      if (bus.CntDec) dec_cyc_q.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic clear_logs();
    gnt_cyc_q = {};
    gnt_who_q = {};
    done_cyc_q = {};
    dec_cyc_q = {};
  endtask

  task automatic wait_gnt(input bit b);
    int n = 0;
    while (!(b ? bus.GntB : bus.GntA) && n < 300) begin
      tick(1);
      n++;
    end
    check("grant_timeout", (n < 300) ? 1 : 0, 1);
    if (b) bus.ReqB = 1'b0;
    else bus.ReqA = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.Busy && n < 400) begin
      tick(1);
      n++;
    end
    check("idle_timeout", (n < 400) ? 1 : 0, 1);
    tick(2);
  endtask

  task automatic serve_both();
    int n = 0;
    while ((bus.ReqA || bus.ReqB) && n < 600) begin
      tick(1);
      if (bus.GntA) bus.ReqA = 1'b0;
      if (bus.GntB) bus.ReqB = 1'b0;
      n++;
    end
    check("serve_timeout", (n < 600) ? 1 : 0, 1);
  endtask

  function automatic int outs_vec();
    return int'({bus.GntA, bus.GntB, bus.DoneA, bus.DoneB, bus.Busy,
                 bus.Owner, bus.CntLoad, bus.CntDec, bus.CntDataIn});
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int c;
    int a;
    Rst_n = 1'b0;
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    bus.ValueA = '0;
    bus.ValueB = '0;
    bus.Abort = 1'b0;

    wait_cyc(2);
    check("reset_outputs", outs_vec(), 0);
    wait_cyc(3);
    Rst_n = 1'b1;

    // N=3 requested in cycle 10
    wait_cyc(10);
    clear_logs();
    bus.ReqA = 1'b1;
    bus.ValueA = 4'd3;
    wait_gnt(1'b0);
    wait_cyc(26);
    check("t1_busy_low_26", int'(bus.Busy), 0);
    check("t1_gnt_n", gnt_cyc_q.size(), 1);
    check("t1_dec_n", dec_cyc_q.size(), 3);
    check("t1_done_n", done_cyc_q.size(), 1);
    if (gnt_cyc_q.size() == 1) check("t1_gnt_cyc", gnt_cyc_q[0], 11);
    if (dec_cyc_q.size() == 3) begin
      check("t1_dec0", dec_cyc_q[0], 15);
      check("t1_dec1", dec_cyc_q[1], 19);
      check("t1_dec2", dec_cyc_q[2], 23);
    end
    if (done_cyc_q.size() == 1) check("t1_done_cyc", done_cyc_q[0], 25);

    // N=0
    wait_cyc(40);
    clear_logs();
    c = cyc;
    bus.ReqA = 1'b1;
    bus.ValueA = 4'd0;
    wait_gnt(1'b0);
    wait_cyc(c + 6);
    check("t2_dec_n", dec_cyc_q.size(), 0);
    check("t2_done_n", done_cyc_q.size(), 1);
    if (gnt_cyc_q.size() == 1) check("t2_gnt_cyc", gnt_cyc_q[0], c + 1);
    if (done_cyc_q.size() == 1) check("t2_done_cyc", done_cyc_q[0], c + 3);

    // simultaneous requests after reset: A, then B, then A again
    Rst_n = 1'b0;
    tick(1);
    Rst_n = 1'b1;
    tick(1);
    clear_logs();
    bus.ReqA = 1'b1; bus.ValueA = 4'd2;
    bus.ReqB = 1'b1; bus.ValueB = 4'd1;
    serve_both();
    wait_idle();
    check("t3_gnt_n", gnt_cyc_q.size(), 2);
    if (gnt_cyc_q.size() == 2 && done_cyc_q.size() >= 1) begin
      check("t3_first_A", gnt_who_q[0], 0);
      check("t3_second_B", gnt_who_q[1], 1);
      check("t3_b_after_doneA", gnt_cyc_q[1], done_cyc_q[0] + 2);
    end
    clear_logs();
    bus.ReqA = 1'b1; bus.ValueA = 4'd1;
    bus.ReqB = 1'b1; bus.ValueB = 4'd1;
    serve_both();
    wait_idle();
    if (gnt_who_q.size() >= 1) check("t3_alternate_A", gnt_who_q[0], 0);
    else check("t3_alternate_n", gnt_who_q.size(), 2);

    // Abort in RUN after one decrement, B pending
    clear_logs();
    bus.ReqA = 1'b1; bus.ValueA = 4'd5;
    wait_gnt(1'b0);
    bus.ReqB = 1'b1; bus.ValueB = 4'd2;
    c = 0;
    while (!bus.CntDec && c < 100) begin tick(1); c++; end
    check("t4_dec_timeout", (c < 100) ? 1 : 0, 1);
    tick(1);
    bus.Abort = 1'b1;
    a = cyc;
    tick(1);
    bus.Abort = 1'b0;
    check("t4_busy_after_abort", int'(bus.Busy), 0);
    wait_gnt(1'b1);
    check("t4_gntB_cyc", cyc, a + 2);
    wait_idle();
    check("t4_single_done_B", done_cyc_q.size(), 1);

    // Reset while running with counter at 2
    bus.ReqA = 1'b1; bus.ValueA = 4'd3;
    wait_gnt(1'b0);
    c = 0;
    while (!(bus.Busy && bus.CntDataOut == 4'd2) && c < 100) begin tick(1); c++; end
    check("t5_cnt2_timeout", (c < 100) ? 1 : 0, 1);
    Rst_n = 1'b0;
    tick(1);
    check("t5_outputs_after_reset", outs_vec(), 0);
    Rst_n = 1'b1;
    clear_logs();
    tick(40);
    check("t5_no_done", done_cyc_q.size(), 0);
    bus.ReqA = 1'b1; bus.ValueA = 4'd1;
    bus.ReqB = 1'b1; bus.ValueB = 4'd1;
    serve_both();
    wait_idle();
    if (gnt_who_q.size() >= 1) check("t5_ptr_reset_A_first", gnt_who_q[0], 0);
    else check("t5_gnt_n", gnt_who_q.size(), 2);

    // ReqB withdrawn before A finishes
    clear_logs();
    bus.ReqA = 1'b1; bus.ValueA = 4'd4;
    wait_gnt(1'b0);
    tick(3);
    bus.ReqB = 1'b1; bus.ValueB = 4'd7;
    tick(5);
    bus.ReqB = 1'b0;
    wait_idle();
    tick(5);
    check("t6_no_gntB", gnt_who_q.sum(), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (bus.GntA) bus.ReqA = 1'b0;
      else if (bus.ReqA && $urandom_range(0, 63) == 0) bus.ReqA = 1'b0;
      else if (!bus.ReqA && $urandom_range(0, 7) == 0) begin
        bus.ReqA = 1'b1;
        bus.ValueA = 4'($urandom_range(0, 15));
      end
      if (bus.GntB) bus.ReqB = 1'b0;
      else if (bus.ReqB && $urandom_range(0, 63) == 0) bus.ReqB = 1'b0;
      else if (!bus.ReqB && $urandom_range(0, 7) == 0) begin
        bus.ReqB = 1'b1;
        bus.ValueB = 4'($urandom_range(0, 15));
      end
      bus.Abort = ($urandom_range(0, 99) == 0);
      Rst_n = !($urandom_range(0, 499) == 0);
    end
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    bus.Abort = 1'b0;
    Rst_n = 1'b1;
    tick(300);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
